// File: rtl/adder_tree_pkg.sv
// rtl/adder_tree_pkg.sv - shared defaults and FSM encoding for the adder tree accumulator
//
// Contents:
//   ADDER_WIDTH_DEF : default leaf operand width of the upstream adder tree
//   CNT_WIDTH_DEF   : default width of the beat-count field
//   state_e         : accumulator FSM states (IDLE = no partial frame, ACCUM = partial frame)
package adder_tree_pkg;

    localparam int ADDER_WIDTH_DEF = 16;
    localparam int CNT_WIDTH_DEF   = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

endpackage

// File: rtl/adder_tree_accum_obuf.sv
// rtl/adder_tree_accum_obuf.sv - one-entry holding register for finished frame totals
//
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset, clears full and data
//   load     : capture data_in and mark the entry full
//   drain    : consumer took the held entry this cycle
//   data_in  : frame total to capture
//   full     : an entry is held (drives out_valid)
//   data_out : held frame total (drives out_sum)
module adder_tree_accum_obuf #(
    parameter int WIDTH = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] data_in,
    output logic             full,
    output logic [WIDTH-1:0] data_out
);

    // Load wins over drain so a drain and a new result in the same cycle
    // leave the buffer full with the new value (no bubble).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full     <= 1'b0;
            data_out <= '0;
        end else if (load) begin
            full     <= 1'b1;
            data_out <= data_in;
        end else if (drain) begin
            full     <= 1'b0;
        end
    end

endmodule

// File: rtl/adder_tree_accum.sv
// rtl/adder_tree_accum.sv - frames adder tree sums into totals of cfg_len+1 beats
//
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : upstream tree sum valid
//   in_ready  : beat accepted when in_valid & in_ready
//   in_sum    : unsigned tree sum, ADDER_WIDTH+1 bits
//   cfg_len   : frame length minus one, sampled on the first beat of a frame
//   flush     : drop the partial frame, blocks input for that cycle
//   out_valid : frame total held
//   out_ready : total consumed when out_valid & out_ready
//   out_sum   : frame total, ADDER_WIDTH+CNT_WIDTH+1 bits
//   busy      : a partial frame is in progress
module adder_tree_accum
    import adder_tree_pkg::*;
#(
    parameter int ADDER_WIDTH = ADDER_WIDTH_DEF,
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [ADDER_WIDTH:0]           in_sum,
    input  logic [CNT_WIDTH-1:0]           cfg_len,
    input  logic                           flush,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ADDER_WIDTH+CNT_WIDTH:0] out_sum,
    output logic                           busy
);

    // Wide enough for 2^CNT_WIDTH beats of the largest tree sum, so no wrap.
    localparam int OW = ADDER_WIDTH + CNT_WIDTH + 1;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_e               state;
    logic [OW-1:0]        acc;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] len_q;

    logic          is_final;
    logic          accept;
    logic          drain;
    logic [OW-1:0] in_ext;
    logic [OW-1:0] result;

    assign in_ext = {{CNT_WIDTH{1'b0}}, in_sum};

    // cnt holds the number of beats already accepted in this frame, so the
    // incoming beat is the last one once cnt reaches len_q.
    assign is_final = (state == IDLE)  ? (cfg_len == '0)
                                       : (cnt == len_q);

    // A final beat can only be taken if the output slot is free or being
    // freed this very cycle; non-final beats never touch the output slot.
    assign in_ready = !flush && !(is_final && out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;

    assign result = (state == IDLE) ? in_ext : (acc + in_ext);

    assign busy = (state == ACCUM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            len_q <= '0;
        end else if (flush) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    len_q <= cfg_len;
                    acc   <= in_ext;
                    cnt   <= CNT_ONE;
                    state <= is_final ? IDLE : ACCUM;
                end
                ACCUM: begin
                    if (is_final) begin
                        state <= IDLE;
                        acc   <= '0;
                        cnt   <= '0;
                    end else begin
                        acc <= result;
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    acc   <= '0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    adder_tree_accum_obuf #(
        .WIDTH (OW)
    ) u_obuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept && is_final),
        .drain    (drain),
        .data_in  (result),
        .full     (out_valid),
        .data_out (out_sum)
    );

endmodule

// File: tb/tb_adder_tree_accum.sv
// tb/tb_adder_tree_accum.sv - self-checking bench for adder_tree_accum
module tb_adder_tree_accum;

    localparam int AW = 16;
    localparam int CW = 8;
    localparam int OW = AW + CW + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [AW:0]   in_sum;
    logic [CW-1:0] cfg_len;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_sum;
    logic          busy;

    always #5 clk = ~clk;

    adder_tree_accum #(
        .ADDER_WIDTH (AW),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .cfg_len   (cfg_len),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: frame progress as "beats seen / frame length / running total"
    int     m_n;
    int     m_flen;
    longint m_sum;
    bit     m_ov;
    longint m_os;
    longint exp_q[$];
    longint got_q[$];
    logic   s_rdy;

    typedef struct {
        int     len;
        longint base;
        longint step;
        longint exp_sum;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_n    = 0;
        m_flen = 0;
        m_sum  = 0;
        m_ov   = 1'b0;
        m_os   = 0;
        exp_q.delete();
        got_q.delete();
    endtask

    // One clock: compare at the falling edge, advance the model, step past the rising edge.
    task automatic cyc();
        int     flen_now;
        bit     fin;
        bit     exp_rdy;
        bit     a;
        bit     d;
        longint res;
        @(negedge clk);
        flen_now = (m_n == 0) ? int'(cfg_len) + 1 : m_flen;
        fin      = (m_n + 1 == flen_now);
        exp_rdy  = !flush && !(fin && m_ov && !out_ready);
        s_rdy    = in_ready;
        chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
        chk("out_valid", {63'd0, out_valid}, {63'd0, m_ov});
        chk("busy", {63'd0, busy}, {63'd0, (m_n != 0)});
        if (m_ov) chk("out_sum", 64'(out_sum), m_os);
        a = in_valid && exp_rdy;
        d = m_ov && out_ready;
        if (d) begin
            got_q.push_back(longint'(out_sum));
            if (exp_q.size() > 0) begin
                chk("drain_order", 64'(out_sum), exp_q.pop_front());
            end else begin
                checks++;
                errors++;
                $display("FAIL spurious_drain actual=%0h required=none", out_sum);
            end
        end
        res = 0;
        if (flush) begin
            m_n   = 0;
            m_sum = 0;
        end else if (a) begin
            m_flen = flen_now;
            m_sum  = m_sum + longint'(in_sum);
            m_n    = m_n + 1;
            if (fin) begin
                res = m_sum;
                exp_q.push_back(m_sum);
                m_n   = 0;
                m_sum = 0;
            end
        end
        if (a && fin) begin
            m_ov = 1'b1;
            m_os = res;
        end else if (d) begin
            m_ov = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sum    = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_out_sum", 64'(out_sum), 64'd0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        tbl[0] = '{3,   1,        1, 10};
        tbl[1] = '{0,   'h1FFFF,  0, 'h1FFFF};
        tbl[2] = '{255, 'h1FFFF,  0, 'h1FFFF00};
        tbl[3] = '{1,   5,        1, 11};
        tbl[4] = '{1,   7,        1, 15};
        tbl[5] = '{3,   1,        0, 4};

        cfg_len = '0;
        do_reset();
        cyc();

        // Table-driven frames with a free-running consumer.
        for (int t = 0; t < 6; t++) begin
            cfg_len   = CW'(tbl[t].len);
            out_ready = 1'b1;
            got_q.delete();
            for (int i = 0; i <= tbl[t].len; i++) begin
                in_valid = 1'b1;
                in_sum   = (AW+1)'(tbl[t].base + longint'(i) * tbl[t].step);
                cyc();
            end
            in_valid = 1'b0;
            if (t == 0) chk("tbl_latency_valid", {63'd0, out_valid}, 64'd1);
            if (t == 0) chk("tbl_busy_after_last", {63'd0, busy}, 64'd0);
            idle(2);
            chk("tbl_count", 64'(got_q.size()), 64'd1);
            if (got_q.size() > 0) chk("tbl_sum", got_q[0], tbl[t].exp_sum);
        end

        // Three single-beat frames back to back.
        got_q.delete();
        cfg_len = '0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_sum   = 17'h1FFFF;
            cyc();
            chk("b2b_ready", {63'd0, s_rdy}, 64'd1);
        end
        idle(2);
        chk("b2b_count", 64'(got_q.size()), 64'd3);
        for (int i = 0; i < got_q.size(); i++) chk("b2b_sum", got_q[i], 64'h1FFFF);

        // Backpressure: two 2-beat frames against a stalled consumer.
        do_reset();
        out_ready = 1'b0;
        cfg_len   = 8'd1;
        in_valid  = 1'b1;
        in_sum = 17'd5; cyc();
        in_sum = 17'd6; cyc();
        in_sum = 17'd7; cyc();
        in_sum = 17'd8; cyc();
        chk("bp_ready_blocked", {63'd0, s_rdy}, 64'd0);
        cyc();
        chk("bp_held_sum", 64'(out_sum), 64'd11);
        chk("bp_held_valid", {63'd0, out_valid}, 64'd1);
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        idle(2);
        chk("bp_count", 64'(got_q.size()), 64'd2);
        if (got_q.size() == 2) begin
            chk("bp_first", got_q[0], 64'd11);
            chk("bp_second", got_q[1], 64'd15);
        end

        // Flush after two of four beats, then a clean frame of ones.
        do_reset();
        cfg_len  = 8'd3;
        in_valid = 1'b1;
        in_sum   = 17'd100;
        cyc();
        cyc();
        flush = 1'b1;
        cyc();
        chk("flush_ready", {63'd0, s_rdy}, 64'd0);
        flush  = 1'b0;
        in_sum = 17'd1;
        for (int i = 0; i < 4; i++) cyc();
        idle(2);
        chk("flush_count", 64'(got_q.size()), 64'd1);
        if (got_q.size() > 0) chk("flush_sum", got_q[0], 64'd4);

        // Asynchronous reset mid-frame while a result is held.
        do_reset();
        out_ready = 1'b0;
        cfg_len   = 8'd0;
        in_valid  = 1'b1;
        in_sum    = 17'd42;
        cyc();
        cfg_len = 8'd3;
        in_sum  = 17'd9;
        cyc();
        in_valid = 1'b0;
        chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        chk("pre_rst_busy", {63'd0, busy}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("async_rst_busy", {63'd0, busy}, 64'd0);
        do_reset();
        idle(2);
        cfg_len  = 8'd1;
        in_valid = 1'b1;
        in_sum = 17'd2; cyc();
        in_sum = 17'd3; cyc();
        idle(2);
        chk("restart_count", 64'(got_q.size()), 64'd1);
        if (got_q.size() > 0) chk("restart_sum", got_q[0], 64'd5);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sum    = ($urandom_range(0, 3) == 0) ? 17'h1FFFF : 17'($urandom);
            cfg_len   = 8'($urandom_range(0, 5));
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 30) == 0);
            cyc();
        end
        flush     = 1'b0;
        out_ready = 1'b1;
        idle(3);
        chk("rand_all_delivered", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
